// File: rtl/cmd_ser_arb_if.sv
// Command-bus bundle between requesters (master) and the serializer/arbiter (slave).
// DATA_WIDTH here is the port width: pass 1 when the serializer runs with NUM_CYCLES==2.
interface cmd_ser_arb_if #(
  parameter int NUM_CHN    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CHN-1:0]            req;
  logic [NUM_CHN*ADDR_WIDTH-1:0] addr;
  logic [NUM_CHN*DATA_WIDTH-1:0] data;
  logic [NUM_CHN-1:0]            ack;
  logic [7:0]                    ad;
  logic                          stb;
  logic                          busy;

  modport master (output req, addr, data, input ack, ad, stb, busy);
  modport slave  (input req, addr, data, output ack, ad, stb, busy);
endinterface

// File: rtl/cmd_ser_arb.sv
// Round-robin arbiter that serializes NUM_CHN parallel address/data commands
// onto the byte-wide ad/stb command bus, NUM_CYCLES bytes per command.
module cmd_ser_arb #(
  parameter int NUM_CHN    = 4,
  parameter int NUM_CYCLES = 6,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GAP        = 0
) (
  input  logic         rst,
  input  logic         clk,
  cmd_ser_arb_if.slave bus
);
  localparam int DW_P = (NUM_CYCLES == 2) ? 1 : DATA_WIDTH;
  localparam int CMDW = 8 * NUM_CYCLES;
  localparam int PW   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CMDW-1:0]     sr_q, sr_d;
  logic [7:0]          ad_q, ad_d;
  logic                stb_q, stb_d;
  logic                busy_q, busy_d;
  logic [NUM_CHN-1:0]  ack_q, ack_d;

  logic                found;
  logic [PW-1:0]       win, ptr_nxt;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DW_P-1:0]     data_sel;
  logic [CMDW-1:0]     cmd;
  logic                last_byte, start;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_CHN; i++) begin
      idx = (32'(ptr_q) + i) % NUM_CHN;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_nxt = '0;
    if (NUM_CHN > 1)
      ptr_nxt = (win == PW'(NUM_CHN - 1)) ? '0 : win + 1'b1;
  end

  // Address occupies bytes 0-1, data from byte 2 up; unused bits go out as 0.
  always_comb begin
    addr_sel = bus.addr[32'(win) * ADDR_WIDTH +: ADDR_WIDTH];
    data_sel = bus.data[32'(win) * DW_P +: DW_P];
    cmd      = CMDW'(addr_sel);
    if (NUM_CYCLES > 2)
      cmd = cmd | (CMDW'(data_sel) << 16);
  end

  assign last_byte = (cnt_q == 4'(NUM_CYCLES - 1));
  assign start = (state_q == S_IDLE)
              || (state_q == S_SEND && last_byte && GAP == 0)
              || (state_q == S_GAP && cnt_q == 4'(GAP - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sr_d    = sr_q;
    ad_d    = '0;
    stb_d   = 1'b0;
    ack_d   = '0;
    if (start && found) begin
      state_d    = S_SEND;
      cnt_d      = '0;
      ptr_d      = ptr_nxt;
      sr_d       = cmd >> 8;
      ad_d       = cmd[7:0];
      stb_d      = 1'b1;
      ack_d[win] = 1'b1;
    end else if (start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_SEND) begin
      if (last_byte) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        ad_d  = sr_q[7:0];
        sr_d  = sr_q >> 8;
      end
    end else if (state_q == S_GAP) begin
      cnt_d = cnt_q + 4'd1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sr_q    <= '0;
      ad_q    <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sr_q    <= sr_d;
      ad_q    <= ad_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ad   = ad_q;
  assign bus.stb  = stb_q;
  assign bus.busy = busy_q;
  assign bus.ack  = ack_q;
endmodule

// File: tb/tb_cmd_ser_arb.sv
// Directed bench for cmd_ser_arb: one instance with GAP=0, one with GAP=2.
module tb_cmd_ser_arb;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cmd_ser_arb_if #(.NUM_CHN(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) bi0 ();
  cmd_ser_arb_if #(.NUM_CHN(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) bi1 ();

  cmd_ser_arb #(.NUM_CHN(4), .NUM_CYCLES(6), .ADDR_WIDTH(16), .DATA_WIDTH(32), .GAP(0))
    dut0 (.rst(rst), .clk(clk), .bus(bi0));
  cmd_ser_arb #(.NUM_CHN(4), .NUM_CYCLES(6), .ADDR_WIDTH(16), .DATA_WIDTH(32), .GAP(2))
    dut1 (.rst(rst), .clk(clk), .bus(bi1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [47:0] c;
    logic [7:0]  t1 [6];
    logic [47:0] t4 [2];
    t1 = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    t4 = '{48'h01234567_A55A, 48'h89ABCDEF_0FF0};
    rst = 1'b1;
    bi0.req = '0; bi0.addr = '0; bi0.data = '0;
    bi1.req = '0; bi1.addr = '0; bi1.data = '0;
    step(); step();
    chk("rst_ad",   32'(bi0.ad),   32'h0);
    chk("rst_stb",  32'(bi0.stb),  32'h0);
    chk("rst_ack",  32'(bi0.ack),  32'h0);
    chk("rst_busy", 32'(bi0.busy), 32'h0);
    rst = 1'b0;

    // Single command, one-cycle latency, byte order
    bi0.addr[15:0] = 16'h1234;
    bi0.data[31:0] = 32'hDEADBEEF;
    bi0.req = 4'b0001;
    for (int b = 0; b < 6; b++) begin
      step();
      chk("t1_ad",   32'(bi0.ad),   32'(t1[b]));
      chk("t1_stb",  32'(bi0.stb),  32'(b == 0));
      chk("t1_ack",  32'(bi0.ack),  (b == 0) ? 32'h1 : 32'h0);
      chk("t1_busy", 32'(bi0.busy), 32'h1);
      if (b == 0) bi0.req = 4'b0000;
    end
    step();
    chk("t1_idle_busy", 32'(bi0.busy), 32'h0);
    chk("t1_idle_ad",   32'(bi0.ad),   32'h0);

    // All four channels at once, back-to-back with no idle cycle
    do_reset();
    bi0.addr = {16'h4400, 16'h3300, 16'h2200, 16'h1100};
    bi0.data = {32'hA0B0C0D3, 32'hA0B0C0D2, 32'hA0B0C0D1, 32'hA0B0C0D0};
    bi0.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      c = {32'hA0B0C0D0 + 32'(k), 16'h1100 * 16'(k + 1)};
      for (int b = 0; b < 6; b++) begin
        step();
        chk("t2_ad",   32'(bi0.ad),   32'(c[8*b +: 8]));
        chk("t2_stb",  32'(bi0.stb),  32'(b == 0));
        chk("t2_ack",  32'(bi0.ack),  (b == 0) ? (32'h1 << k) : 32'h0);
        chk("t2_busy", 32'(bi0.busy), 32'h1);
        if (b == 0) bi0.req[k] = 1'b0;
      end
    end
    step();
    chk("t2_idle_busy", 32'(bi0.busy), 32'h0);

    // ch0 and ch2 requesting continuously: grants alternate
    do_reset();
    bi0.req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 6; b++) begin
        step();
        chk("t3_ack", 32'(bi0.ack), (b == 0) ? ((g % 2 == 1) ? 32'h4 : 32'h1) : 32'h0);
        if (b == 1) chk("t3_ad", 32'(bi0.ad), (g % 2 == 1) ? 32'h33 : 32'h11);
      end
    end
    bi0.req = '0;
    step();
    chk("t3_idle_busy", 32'(bi0.busy), 32'h0);

    // GAP=2 instance: stb 8 cycles apart, gap cycles busy with ad=0
    do_reset();
    bi1.addr[31:0] = {16'h0FF0, 16'hA55A};
    bi1.data[63:0] = {32'h89ABCDEF, 32'h01234567};
    bi1.req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 8; b++) begin
        step();
        chk("t4_busy", 32'(bi1.busy), 32'h1);
        chk("t4_stb",  32'(bi1.stb),  32'(b == 0));
        chk("t4_ack",  32'(bi1.ack),  (b == 0) ? (32'h1 << k) : 32'h0);
        c = t4[k];
        chk("t4_ad",   32'(bi1.ad),   (b < 6) ? 32'(c[8*b +: 8]) : 32'h0);
        if (b == 0) bi1.req[k] = 1'b0;
      end
    end
    step();
    chk("t4_idle_busy", 32'(bi1.busy), 32'h0);

    // Async reset during byte 3 of ch1, then ch1 re-served from byte 0
    do_reset();
    bi0.req = 4'b1010;
    step();
    chk("t5_ack0", 32'(bi0.ack), 32'h2);
    step(); step(); step();
    chk("t5_ad3",   32'(bi0.ad),   32'hC0);
    chk("t5_busy3", 32'(bi0.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ad",   32'(bi0.ad),   32'h0);
    chk("t5_rst_stb",  32'(bi0.stb),  32'h0);
    chk("t5_rst_ack",  32'(bi0.ack),  32'h0);
    chk("t5_rst_busy", 32'(bi0.busy), 32'h0);
    #1 rst = 1'b0;
    step();
    chk("t5_re_ack", 32'(bi0.ack), 32'h2);
    chk("t5_re_stb", 32'(bi0.stb), 32'h1);
    chk("t5_re_ad0", 32'(bi0.ad),  32'h00);
    bi0.req = 4'b1000;
    step();
    chk("t5_re_ad1", 32'(bi0.ad), 32'h22);
    bi0.req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
